// File: rtl/hazard_if.sv
// hazard_if: decode/writeback/execute hazard signals between the pipeline and the hazard controller.
interface hazard_if #(parameter int REGNO_BITS = 4);
    logic                       dec_valid;
    logic [REGNO_BITS-1:0]      dec_regno1;
    logic [REGNO_BITS-1:0]      dec_regno2;
    logic                       dec_use1;
    logic                       dec_use2;
    logic                       dec_wrtEn;
    logic [REGNO_BITS-1:0]      dec_wrtRegno;
    logic                       wb_valid;
    logic [REGNO_BITS-1:0]      wb_regno;
    logic                       ex_mispredict;
    logic                       issue;
    logic                       stall;
    logic                       flush;
    logic [2**REGNO_BITS-1:0]   busy_mask;
    logic [1:0]                 state;
    logic                       err;
    modport master (
        output dec_valid, dec_regno1, dec_regno2, dec_use1, dec_use2, dec_wrtEn, dec_wrtRegno,
               wb_valid, wb_regno, ex_mispredict,
        input  issue, stall, flush, busy_mask, state, err
    );
    modport slave (
        input  dec_valid, dec_regno1, dec_regno2, dec_use1, dec_use2, dec_wrtEn, dec_wrtRegno,
               wb_valid, wb_regno, ex_mispredict,
        output issue, stall, flush, busy_mask, state, err
    );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: per-register pending-write counters driving decode interlock and mispredict flush.
module hazard_controller #(
    parameter int REGNO_BITS = 4,
    parameter int CNT_BITS   = 2
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);
    localparam int NREG = 2**REGNO_BITS;
    localparam logic [CNT_BITS-1:0] CMAX = '1;
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
    state_t                st, st_nxt;
    logic [CNT_BITS-1:0]   cnt     [NREG];
    logic [CNT_BITS-1:0]   cnt_nxt [NREG];
    logic [CNT_BITS:0]     up      [NREG];
    logic [CNT_BITS:0]     dn      [NREG];
    logic [NREG-1:0]       under;
    logic                  de_wr_valid;
    logic [REGNO_BITS-1:0] de_wr_regno;
    logic                  hazard;
    logic                  issue;
    logic                  err_q;
    // Hazards look only at registered counters: a same-cycle writeback does not unblock decode.
    always_comb begin
        hazard = (hz.dec_use1 && cnt[hz.dec_regno1] != '0) ||
                 (hz.dec_use2 && cnt[hz.dec_regno2] != '0) ||
                 (hz.dec_wrtEn && cnt[hz.dec_wrtRegno] == CMAX);
        issue  = hz.dec_valid && !hazard && st != FLUSH && !hz.ex_mispredict;
        st_nxt = hz.ex_mispredict ? FLUSH :
                 (st != FLUSH && hz.dec_valid && hazard) ? STALL : RUN;
    end
    // Squashing the DE shadow and a writeback on the same register decrement it by two.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            up[r] = {1'b0, cnt[r]} + (CNT_BITS+1)'(issue && hz.dec_wrtEn && hz.dec_wrtRegno == REGNO_BITS'(r));
            dn[r] = (CNT_BITS+1)'(hz.wb_valid && hz.wb_regno == REGNO_BITS'(r)) +
                    (CNT_BITS+1)'(hz.ex_mispredict && de_wr_valid && de_wr_regno == REGNO_BITS'(r));
            under[r] = up[r] < dn[r];
            cnt_nxt[r] = under[r] ? '0 : CNT_BITS'(up[r] - dn[r]);
            hz.busy_mask[r] = cnt[r] != '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= RUN;
            err_q       <= 1'b0;
            de_wr_valid <= 1'b0;
            de_wr_regno <= '0;
            cnt         <= '{default: '0};
        end else begin
            st          <= st_nxt;
            err_q       <= err_q | (|under);
            de_wr_valid <= issue && hz.dec_wrtEn;
            de_wr_regno <= hz.dec_wrtRegno;
            cnt         <= cnt_nxt;
        end
    end
    assign hz.issue = issue;
    assign hz.stall = (hz.dec_valid && !issue) || st == FLUSH;
    assign hz.flush = hz.ex_mispredict || st == FLUSH;
    assign hz.state = st;
    assign hz.err   = err_q;
endmodule
